// File: rtl/model_vector_sinh_sequencer.sv
// Vector sequencer for a scalar sinh unit.
//
// Walks a vector of SIZE_IN elements through an external scalar unit one at a
// time: requests an element (DATA_ENABLE), forwards it (SCALAR_START /
// SCALAR_DATA_IN), waits for the result (SCALAR_READY) and emits it
// (DATA_OUT_ENABLE / DATA_OUT). READY pulses together with the last result,
// or one cycle after START for an empty vector. OVERFLOW_OUT is the sticky
// OR of the scalar overflow flags seen during the current vector.
//
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   START, SIZE_IN, READY    vector handshake
//   DATA_ENABLE              request for the next input element
//   DATA_IN_ENABLE, DATA_IN  input element
//   DATA_OUT_ENABLE,
//   DATA_OUT, OVERFLOW_OUT   result element and sticky overflow
//   SCALAR_*                 interface to the scalar sinh unit
module model_vector_sinh_sequencer #(
  parameter int unsigned DATA_SIZE    = 64,
  parameter int unsigned CONTROL_SIZE = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic [CONTROL_SIZE-1:0] SIZE_IN,
  input  logic                    DATA_IN_ENABLE,
  input  logic [DATA_SIZE-1:0]    DATA_IN,
  output logic                    DATA_ENABLE,
  output logic                    DATA_OUT_ENABLE,
  output logic [DATA_SIZE-1:0]    DATA_OUT,
  output logic                    OVERFLOW_OUT,
  output logic                    SCALAR_START,
  output logic [DATA_SIZE-1:0]    SCALAR_DATA_IN,
  input  logic                    SCALAR_READY,
  input  logic [DATA_SIZE-1:0]    SCALAR_DATA_OUT,
  input  logic                    SCALAR_OVERFLOW_IN
);

  typedef enum logic [1:0] {
    StStarter = 2'b00,
    StInput   = 2'b01,
    StEnder   = 2'b10
  } state_e;

  state_e                  state_q, state_d;
  logic [CONTROL_SIZE-1:0] index_q, index_d;
  logic [CONTROL_SIZE-1:0] size_q, size_d;
  logic                    ready_q, ready_d;
  logic                    data_enable_q, data_enable_d;
  logic                    data_out_enable_q, data_out_enable_d;
  logic                    scalar_start_q, scalar_start_d;
  logic                    overflow_q, overflow_d;
  logic [DATA_SIZE-1:0]    data_out_q, data_out_d;
  logic [DATA_SIZE-1:0]    scalar_data_in_q, scalar_data_in_d;

  logic last_element;
  assign last_element = (index_q == size_q - CONTROL_SIZE'(1));

  always_comb begin
    state_d           = state_q;
    index_d           = index_q;
    size_d            = size_q;
    overflow_d        = overflow_q;
    data_out_d        = data_out_q;
    scalar_data_in_d  = scalar_data_in_q;
    // Strobes default low so each one lasts exactly one cycle.
    ready_d           = 1'b0;
    data_enable_d     = 1'b0;
    data_out_enable_d = 1'b0;
    scalar_start_d    = 1'b0;

    case (state_q)
      StStarter: begin
        if (START) begin
          if (SIZE_IN != '0) begin
            size_d        = SIZE_IN;
            index_d       = '0;
            overflow_d    = 1'b0;
            data_enable_d = 1'b1;
            state_d       = StInput;
          end else begin
            // Empty vector: acknowledge immediately, nothing to process.
            ready_d = 1'b1;
          end
        end
      end

      StInput: begin
        if (DATA_IN_ENABLE) begin
          scalar_data_in_d = DATA_IN;
          scalar_start_d   = 1'b1;
          state_d          = StEnder;
        end
      end

      StEnder: begin
        if (SCALAR_READY) begin
          data_out_d        = SCALAR_DATA_OUT;
          data_out_enable_d = 1'b1;
          overflow_d        = overflow_q | SCALAR_OVERFLOW_IN;
          if (last_element) begin
            ready_d = 1'b1;
            index_d = '0;
            state_d = StStarter;
          end else begin
            index_d       = index_q + CONTROL_SIZE'(1);
            data_enable_d = 1'b1;
            state_d       = StInput;
          end
        end
      end

      // Unused encoding recovers to the idle state.
      default: state_d = StStarter;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q           <= StStarter;
      index_q           <= '0;
      size_q            <= '0;
      ready_q           <= 1'b0;
      data_enable_q     <= 1'b0;
      data_out_enable_q <= 1'b0;
      scalar_start_q    <= 1'b0;
      overflow_q        <= 1'b0;
      data_out_q        <= '0;
      scalar_data_in_q  <= '0;
    end else begin
      state_q           <= state_d;
      index_q           <= index_d;
      size_q            <= size_d;
      ready_q           <= ready_d;
      data_enable_q     <= data_enable_d;
      data_out_enable_q <= data_out_enable_d;
      scalar_start_q    <= scalar_start_d;
      overflow_q        <= overflow_d;
      data_out_q        <= data_out_d;
      scalar_data_in_q  <= scalar_data_in_d;
    end
  end

  assign READY           = ready_q;
  assign DATA_ENABLE     = data_enable_q;
  assign DATA_OUT_ENABLE = data_out_enable_q;
  assign DATA_OUT        = data_out_q;
  assign OVERFLOW_OUT    = overflow_q;
  assign SCALAR_START    = scalar_start_q;
  assign SCALAR_DATA_IN  = scalar_data_in_q;

endmodule

// File: tb/tb_model_vector_sinh_sequencer.sv
// Bench for model_vector_sinh_sequencer: table of directed vectors plus
// randomized vectors, a scalar-unit stub and an output monitor.
module tb_model_vector_sinh_sequencer;

  logic        CLK;
  logic        RST;
  logic        START;
  logic        READY;
  logic [63:0] SIZE_IN;
  logic        DATA_IN_ENABLE;
  logic [63:0] DATA_IN;
  logic        DATA_ENABLE;
  logic        DATA_OUT_ENABLE;
  logic [63:0] DATA_OUT;
  logic        OVERFLOW_OUT;
  logic        SCALAR_START;
  logic [63:0] SCALAR_DATA_IN;
  logic        SCALAR_READY;
  logic [63:0] SCALAR_DATA_OUT;
  logic        SCALAR_OVERFLOW_IN;

  model_vector_sinh_sequencer #(
    .DATA_SIZE   (64),
    .CONTROL_SIZE(64)
  ) dut (
    .CLK               (CLK),
    .RST               (RST),
    .START             (START),
    .READY             (READY),
    .SIZE_IN           (SIZE_IN),
    .DATA_IN_ENABLE    (DATA_IN_ENABLE),
    .DATA_IN           (DATA_IN),
    .DATA_ENABLE       (DATA_ENABLE),
    .DATA_OUT_ENABLE   (DATA_OUT_ENABLE),
    .DATA_OUT          (DATA_OUT),
    .OVERFLOW_OUT      (OVERFLOW_OUT),
    .SCALAR_START      (SCALAR_START),
    .SCALAR_DATA_IN    (SCALAR_DATA_IN),
    .SCALAR_READY      (SCALAR_READY),
    .SCALAR_DATA_OUT   (SCALAR_DATA_OUT),
    .SCALAR_OVERFLOW_IN(SCALAR_OVERFLOW_IN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Scalar unit stub: returns operand XOR 1 after stub_delay cycles.
  logic        stub_ready = 1'b0;
  logic        spur_ready = 1'b0;
  logic [63:0] stub_dout  = '0;
  logic        stub_ovf   = 1'b0;
  logic [63:0] stub_op    = '0;
  logic        stub_flag  = 1'b0;
  logic [3:0]  stub_flags = '0;
  int          stub_cnt   = 0;
  int          stub_delay = 2;
  int          stub_elem  = 0;

  assign SCALAR_READY       = stub_ready | spur_ready;
  assign SCALAR_DATA_OUT    = stub_dout;
  assign SCALAR_OVERFLOW_IN = stub_ovf;

  always @(negedge CLK) begin
    stub_ready = 1'b0;
    if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        stub_ready = 1'b1;
        stub_dout  = stub_op ^ 64'h1;
        stub_ovf   = stub_flag;
      end
    end
    if (SCALAR_START) begin
      stub_op   = SCALAR_DATA_IN;
      stub_cnt  = stub_delay;
      stub_flag = (stub_elem < 4) ? stub_flags[stub_elem] : 1'b0;
      stub_elem++;
    end
  end

  // Output monitor.
  logic [63:0] out_q[$];
  logic        ovo_q[$];
  logic        rdy_q[$];
  int doe_cnt = 0, rdy_cnt = 0, de_cnt = 0, ss_cnt = 0;

  always @(negedge CLK) begin
    if (!RST) begin
      if (DATA_OUT_ENABLE) begin
        out_q.push_back(DATA_OUT);
        ovo_q.push_back(OVERFLOW_OUT);
        rdy_q.push_back(READY);
        doe_cnt++;
      end
      if (READY)        rdy_cnt++;
      if (DATA_ENABLE)  de_cnt++;
      if (SCALAR_START) ss_cnt++;
    end
  end

  task automatic clear_mon();
    out_q.delete();
    ovo_q.delete();
    rdy_q.delete();
    doe_cnt = 0;
    rdy_cnt = 0;
    de_cnt  = 0;
    ss_cnt  = 0;
  endtask

  typedef struct packed {
    int unsigned      size;
    logic [3:0][63:0] din;
    logic [3:0][63:0] dexp;
    logic [3:0]       ovf;
    logic             exp_ovf;
    int               stall_elem;
    int               stall_len;
    int               delay;
    logic             spurious;
    int               abort_at;
  } vec_t;

  function automatic vec_t blank(input int unsigned size, input int delay);
    vec_t v;
    v            = '0;
    v.size       = size;
    v.delay      = delay;
    v.stall_elem = -1;
    v.abort_at   = -1;
    return v;
  endfunction

  // Applies one vector, called and returning on a falling edge.
  task automatic run_vec(input vec_t v);
    int   n;
    logic run_ovf;
    bit   ok;
    n = int'(v.size);
    clear_mon();
    stub_elem  = 0;
    stub_delay = v.delay;
    stub_flags = v.ovf;
    START   = 1'b1;
    SIZE_IN = 64'(n);
    @(negedge CLK);
    START = 1'b0;
    if (n == 0) begin
      chk("zero_ready", 64'(READY), 64'(1));
      repeat (5) @(negedge CLK);
      chk("zero_ready_cnt", 64'(rdy_cnt), 64'(1));
      chk("zero_de_cnt", 64'(de_cnt), 64'(0));
      chk("zero_ss_cnt", 64'(ss_cnt), 64'(0));
      chk("zero_doe_cnt", 64'(doe_cnt), 64'(0));
      return;
    end
    chk("start_ovf_clear", 64'(OVERFLOW_OUT), 64'(0));
    for (int i = 0; i < n; i++) begin
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
        if (DATA_ENABLE) begin
          ok = 1'b1;
          break;
        end
        @(negedge CLK);
      end
      chk("data_enable_seen", 64'(ok), 64'(1));
      if (!ok) return;
      if (v.spurious) begin
        START      = 1'b1;
        SIZE_IN    = 64'd7;
        spur_ready = 1'b1;
        @(negedge CLK);
        START      = 1'b0;
        spur_ready = 1'b0;
      end
      if (i == v.stall_elem) begin
        repeat (v.stall_len) begin
          @(negedge CLK);
          chk("stall_no_scalar_start", 64'(SCALAR_START), 64'(0));
        end
      end
      DATA_IN_ENABLE = 1'b1;
      DATA_IN        = v.din[i];
      @(negedge CLK);
      DATA_IN_ENABLE = 1'b0;
      DATA_IN        = 64'hFFFF_FFFF_FFFF_FFFF;
      chk("scalar_start_latency", 64'(SCALAR_START), 64'(1));
      chk("scalar_operand", SCALAR_DATA_IN, v.din[i]);
      if (v.spurious) begin
        START          = 1'b1;
        DATA_IN_ENABLE = 1'b1;
        DATA_IN        = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge CLK);
        START          = 1'b0;
        DATA_IN_ENABLE = 1'b0;
      end
      if (i == v.abort_at) begin
        chk("pre_reset_ovf", 64'(OVERFLOW_OUT), 64'(1));
        #2 RST = 1'b1;
        #1;
        chk("rst_ready", 64'(READY), 64'(0));
        chk("rst_data_enable", 64'(DATA_ENABLE), 64'(0));
        chk("rst_doe", 64'(DATA_OUT_ENABLE), 64'(0));
        chk("rst_scalar_start", 64'(SCALAR_START), 64'(0));
        chk("rst_ovf", 64'(OVERFLOW_OUT), 64'(0));
        chk("rst_data_out", DATA_OUT, 64'(0));
        chk("rst_scalar_data_in", SCALAR_DATA_IN, 64'(0));
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        clear_mon();
        repeat (12) @(negedge CLK);
        chk("late_doe_cnt", 64'(doe_cnt), 64'(0));
        chk("late_ss_cnt", 64'(ss_cnt), 64'(0));
        chk("late_de_cnt", 64'(de_cnt), 64'(0));
        chk("late_ready_cnt", 64'(rdy_cnt), 64'(0));
        return;
      end
    end
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (READY) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    chk("ready_seen", 64'(ok), 64'(1));
    repeat (3) @(negedge CLK);
    chk("doe_cnt", 64'(doe_cnt), 64'(n));
    chk("ss_cnt", 64'(ss_cnt), 64'(n));
    chk("de_cnt", 64'(de_cnt), 64'(n));
    chk("ready_cnt", 64'(rdy_cnt), 64'(1));
    run_ovf = 1'b0;
    for (int i = 0; i < n && i < out_q.size(); i++) begin
      run_ovf = run_ovf | v.ovf[i];
      chk($sformatf("data_out[%0d]", i), out_q[i], v.dexp[i]);
      chk($sformatf("ovf_at_doe[%0d]", i), 64'(ovo_q[i]), 64'(run_ovf));
      chk($sformatf("ready_at_doe[%0d]", i), 64'(rdy_q[i]), 64'(i == n - 1));
    end
    chk("final_ovf", 64'(OVERFLOW_OUT), 64'(v.exp_ovf));
  endtask

  vec_t tbl[8];
  vec_t rv;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = blank(3, 2);
    tbl[0].din[0]  = 64'h0000_0000_0000_0000;
    tbl[0].din[1]  = 64'h3FF0_0000_0000_0000;
    tbl[0].din[2]  = 64'hBFF0_0000_0000_0000;
    tbl[0].dexp[0] = 64'h0000_0000_0000_0001;
    tbl[0].dexp[1] = 64'h3FF0_0000_0000_0001;
    tbl[0].dexp[2] = 64'hBFF0_0000_0000_0001;
    tbl[1] = blank(0, 2);
    tbl[2] = blank(2, 2);
    tbl[2].din[0]  = 64'h4000_0000_0000_0000;
    tbl[2].din[1]  = 64'hC000_0000_0000_0000;
    tbl[2].dexp[0] = 64'h4000_0000_0000_0001;
    tbl[2].dexp[1] = 64'hC000_0000_0000_0001;
    tbl[2].ovf     = 4'b0001;
    tbl[2].exp_ovf = 1'b1;
    tbl[3] = blank(1, 3);
    tbl[3].din[0]  = 64'h7FF0_0000_0000_0000;
    tbl[3].dexp[0] = 64'h7FF0_0000_0000_0001;
    tbl[4] = blank(2, 3);
    tbl[4].din[0]     = 64'h1234_5678_9ABC_DEF0;
    tbl[4].din[1]     = 64'h0FED_CBA9_8765_4321;
    tbl[4].dexp[0]    = 64'h1234_5678_9ABC_DEF1;
    tbl[4].dexp[1]    = 64'h0FED_CBA9_8765_4320;
    tbl[4].stall_elem = 0;
    tbl[4].stall_len  = 10;
    tbl[5] = blank(2, 3);
    tbl[5].din[0]   = 64'hAAAA_5555_AAAA_5555;
    tbl[5].din[1]   = 64'h5555_AAAA_5555_AAAA;
    tbl[5].dexp[0]  = 64'hAAAA_5555_AAAA_5554;
    tbl[5].dexp[1]  = 64'h5555_AAAA_5555_AAAB;
    tbl[5].spurious = 1'b1;
    tbl[6] = blank(4, 6);
    tbl[6].din[0]   = 64'h4010_0000_0000_0000;
    tbl[6].din[1]   = 64'h4020_0000_0000_0000;
    tbl[6].ovf      = 4'b0001;
    tbl[6].abort_at = 1;
    tbl[7] = blank(1, 2);
    tbl[7].din[0]  = 64'h3FE0_0000_0000_0000;
    tbl[7].dexp[0] = 64'h3FE0_0000_0000_0001;

    START          = 1'b0;
    SIZE_IN        = '0;
    DATA_IN_ENABLE = 1'b0;
    DATA_IN        = '0;
    RST            = 1'b0;
    #1 RST = 1'b1;
    #1;
    chk("reset_ready", 64'(READY), 64'(0));
    chk("reset_data_enable", 64'(DATA_ENABLE), 64'(0));
    chk("reset_doe", 64'(DATA_OUT_ENABLE), 64'(0));
    chk("reset_scalar_start", 64'(SCALAR_START), 64'(0));
    chk("reset_ovf", 64'(OVERFLOW_OUT), 64'(0));
    chk("reset_data_out", DATA_OUT, 64'(0));
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    for (int t = 0; t < 8; t++) begin
      run_vec(tbl[t]);
      repeat (2) @(negedge CLK);
    end

    for (int r = 0; r < 20; r++) begin
      rv = blank($urandom_range(1, 4), int'($urandom_range(1, 5)));
      for (int e = 0; e < 4; e++) begin
        rv.din[e]  = {$urandom, $urandom};
        rv.dexp[e] = rv.din[e] ^ 64'h1;
        rv.ovf[e]  = ($urandom_range(0, 3) == 0);
        if (e < int'(rv.size)) rv.exp_ovf = rv.exp_ovf | rv.ovf[e];
      end
      rv.stall_elem = int'($urandom_range(0, 3));
      rv.stall_len  = int'($urandom_range(0, 4));
      run_vec(rv);
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/model_vector_sinh_sequencer.md
MODEL_VECTOR_SINH_SEQUENCER -- requirements
Module: model_vector_sinh_sequencer

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 64, width of one element as an IEEE-754 double bit pattern.
REQ-002 SHALL have parameter CONTROL_SIZE, default 64, width of the vector length and of the element index.
REQ-003 SHALL have port CLK  in  1  clock; all state updates occur on the rising edge.
REQ-004 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port START  in  1  request to process one vector.
REQ-006 SHALL have port READY  out  1  one-cycle pulse when the whole vector is done.
REQ-007 SHALL have port SIZE_IN  in  CONTROL_SIZE  element count, sampled when START is accepted.
REQ-008 SHALL have port DATA_IN_ENABLE  in  1  DATA_IN holds a valid element.
REQ-009 SHALL have port DATA_IN  in  DATA_SIZE  input element.
REQ-010 SHALL have port DATA_ENABLE  out  1  one-cycle pulse requesting the next input element.
REQ-011 SHALL have port DATA_OUT_ENABLE  out  1  one-cycle pulse; DATA_OUT holds a valid result.
REQ-012 SHALL have port DATA_OUT  out  DATA_SIZE  sinh result element.
REQ-013 SHALL have port OVERFLOW_OUT  out  1  sticky OR of per-element overflow over the current vector.
REQ-014 SHALL have port SCALAR_START  out  1  one-cycle start pulse to the scalar sinh unit.
REQ-015 SHALL have port SCALAR_DATA_IN  out  DATA_SIZE  operand for the scalar unit.
REQ-016 SHALL have port SCALAR_READY  in  1  scalar unit result valid.
REQ-017 SHALL have port SCALAR_DATA_OUT  in  DATA_SIZE  scalar result.
REQ-018 SHALL have port SCALAR_OVERFLOW_IN  in  1  scalar overflow flag, valid together with SCALAR_READY.

Function
REQ-019 SHALL implement the FSM states STARTER, INPUT and ENDER, plus an internal index counter and a size register, both CONTROL_SIZE bits wide.
REQ-020 In STARTER, on START=1 with SIZE_IN>0: latch SIZE_IN, set index=0, clear OVERFLOW_OUT, pulse DATA_ENABLE on the next cycle, go to INPUT.
REQ-021 In STARTER, on START=1 with SIZE_IN=0: pulse READY on the next cycle, emit no DATA_OUT_ENABLE, remain in STARTER.
REQ-022 In INPUT, on DATA_IN_ENABLE=1: register DATA_IN into SCALAR_DATA_IN, pulse SCALAR_START on the next cycle for exactly one cycle, go to ENDER.
REQ-023 In INPUT, the block SHALL wait indefinitely while DATA_IN_ENABLE=0, with outputs held.
REQ-024 In ENDER, on SCALAR_READY=1: register SCALAR_DATA_OUT into DATA_OUT, pulse DATA_OUT_ENABLE on the next cycle, and set OVERFLOW_OUT to OVERFLOW_OUT OR SCALAR_OVERFLOW_IN.
REQ-025 In ENDER, on SCALAR_READY=1 with index=size-1: pulse READY in the same cycle as the final DATA_OUT_ENABLE, reset index to 0, return to STARTER.
REQ-026 In ENDER, on SCALAR_READY=1 with index<size-1: increment index, pulse DATA_ENABLE in the same cycle as DATA_OUT_ENABLE, return to INPUT.
REQ-027 START SHALL be ignored outside STARTER; DATA_IN_ENABLE SHALL be ignored outside INPUT; SCALAR_READY SHALL be ignored outside ENDER.
REQ-028 READY, DATA_ENABLE, DATA_OUT_ENABLE and SCALAR_START SHALL each be high for exactly one cycle per event and low otherwise.
REQ-029 DATA_OUT, SCALAR_DATA_IN and OVERFLOW_OUT SHALL hold their last value until next updated.
REQ-030 Latency: DATA_IN_ENABLE sampled -> SCALAR_START high 1 cycle later; SCALAR_READY sampled -> DATA_OUT_ENABLE high 1 cycle later.
REQ-031 Data SHALL pass through bit-exact; the block performs no arithmetic on element values.
REQ-032 An unreachable FSM encoding SHALL return to STARTER on the next clock.

Reset
REQ-033 While RST=1, the block SHALL asynchronously force READY, DATA_ENABLE, DATA_OUT_ENABLE, SCALAR_START and OVERFLOW_OUT to 0.
REQ-034 While RST=1, the block SHALL force DATA_OUT and SCALAR_DATA_IN to all zeros, index and size to 0, and the state to STARTER.
REQ-035 Reset asserted mid-vector SHALL abandon the vector; after RST falls, the block SHALL accept only a new START, and SCALAR_READY arriving later SHALL be ignored.

Verification
REQ-036 SIZE_IN=3, inputs 0x0000000000000000, 0x3FF0000000000000, 0xBFF0000000000000; scalar stub returns each operand XOR 0x1 after 2 cycles -> three DATA_OUT_ENABLE pulses with 0x0000000000000001, 0x3FF0000000000001, 0xBFF0000000000001 in order; READY coincides with the third pulse; OVERFLOW_OUT=0.
REQ-037 SIZE_IN=0 with START -> READY pulse 1 cycle later; no DATA_ENABLE, SCALAR_START or DATA_OUT_ENABLE.
REQ-038 SIZE_IN=2, stub asserts SCALAR_OVERFLOW_IN on element 0 only -> OVERFLOW_OUT=1 from the first DATA_OUT_ENABLE onward, still 1 at READY; a following START clears it to 0.
REQ-039 START pulsed again while in INPUT/ENDER, and spurious DATA_IN_ENABLE/SCALAR_READY in the wrong state -> no extra SCALAR_START or DATA_OUT_ENABLE; element count unchanged.
REQ-040 RST pulsed while in ENDER of a SIZE_IN=4 vector -> all outputs 0 immediately (asynchronous); a late SCALAR_READY produces no DATA_OUT_ENABLE; a new SIZE_IN=1 vector completes normally.
REQ-041 Input stalled 10 cycles (DATA_IN_ENABLE=0) in INPUT -> no SCALAR_START during the stall; SCALAR_START appears exactly 1 cycle after DATA_IN_ENABLE.
